csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR register file and trap unit for the rv32i core; responder to the control unit's CSR decoder. Executes CSRRW/S/C and immediate variants using the decoder's `csr_w`/`csr_inm` strobes, returns the old CSR value for rd write-back, and owns the cycle/instret counters. Also records trap state (mepc/mcause/mtval/mstatus) and supplies the redirect PC for trap entry and `mret`.

## Interface
- `RESET_MTVEC`, 32'h0000_0000, mtvec reset value (bits [1:0] forced 0)
- `HART_ID`, 32'd0, value read from mhartid
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `csr_w`  in  1  CSR instruction valid this cycle
- `csr_inm`  in  1  source is `zimm` (1) or `rs1_data` (0)
- `f3`  in  3  funct3; [1:0] 01=RW, 10=RS, 11=RC
- `csr_addr`  in  12  CSR address
- `rs1_data`  in  32  register source operand
- `zimm`  in  5  immediate source, zero-extended
- `retire`  in  1  one instruction retired this cycle
- `trap`  in  1  take synchronous exception
- `trap_cause`  in  4  exception code (interrupt bit 0)
- `trap_pc`  in  32  PC of faulting instruction
- `trap_val`  in  32  mtval value
- `mret`  in  1  mret executing
- `rd_data`  out  32  old CSR value (combinational)
- `illegal`  out  1  unimplemented address or write to read-only CSR
- `redirect`  out  1  PC redirect valid (= `trap | mret`)
- `redirect_pc`  out  32  mtvec base on trap, mepc on mret

## Operation
- Implemented: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] read 2'b11), misa 0x301 (RO, 32'h4000_0100), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, cycle/h 0xC00/0xC80 (RO), instret/h 0xC02/0xC82 (RO), mhartid 0xF14 (RO).
- Source `s` = `csr_inm` ? {27'b0,zimm} : `rs1_data`.
- New value: RW → s; RS → old|s; RC → old&~s.
- Write occurs iff `csr_w` & !`illegal` & (RW or s≠0). RS/RC with s=0 read only; never illegal for RO addresses.
- `illegal` = `csr_w` & (address unimplemented, or addr[11:10]==2'b11 and write would occur). f3[1:0]=00 with `csr_w` → illegal.
- mepc bits [1:0] and mtvec bits [1:0] always read 0; unlisted mstatus bits read 0, writes ignored.
- Trap: mepc←trap_pc, mcause←{28'b0,trap_cause}, mtval←trap_val, MPIE←MIE, MIE←0.
- mret: MIE←MPIE, MPIE←1.
- Counters: mcycle +1 every cycle; minstret +1 when `retire`. 64-bit, wrap 2^64-1 → 0.
- Priority in one cycle: trap > mret > CSR write; CSR write to a counter half overrides that cycle's increment of the full 64-bit counter (other half holds).

## Timing
- `rd_data`, `illegal`, `redirect`, `redirect_pc` combinational from inputs/state, same cycle.
- All state updates on rising `clk`; visible to the instruction in the next cycle.
- Reset (async, any cycle incl. mid-trap): mstatus MIE=MPIE=0, mtvec=RESET_MTVEC, mscratch/mepc/mcause/mtval=0, counters=0. Outputs follow combinationally; `redirect`=0 with inputs low.
- Trap/mret with `csr_w` same cycle: CSR write suppressed, `rd_data` still driven.

## Configuration
- `CSR_COUNTERS_EN` defined: mcycle/minstret and user aliases implemented as above.
- Undefined: counter addresses read 0, are not illegal, writes discarded; counter flops and `csr_counter64` not instantiated; `retire` ignored.

## Structure
- `csr_pkg`: CSR address localparams, mstatus bit indices, misa constant, exception code constants, f3 op encodings.
- Sub-module `csr_counter64`: 64-bit counter with increment enable and independent lo/hi write ports; instantiated for mcycle and minstret.

## Test plan
- Reset, read mstatus/mtvec/mcycle → 32'h0000_1800, RESET_MTVEC, small count; mhartid → HART_ID.
- CSRRW mscratch←32'hDEAD_BEEF, then CSRRS rs1=0 → rd_data 32'hDEAD_BEEF, no write; CSRRCI zimm=5'h0F → 32'hDEAD_BEE0.
- CSRRW to 0xC00 → `illegal`=1, cycle unchanged; CSRRS rs1=0 to 0xC00 → `illegal`=0; address 0x7C0 → `illegal`=1.
- MIE=1, trap cause 2, pc 32'h0000_0102 → redirect_pc=mtvec, next cycle mepc=32'h0000_0100, mcause=2, MIE=0, MPIE=1; mret → redirect_pc=32'h0000_0100, then MIE=1, MPIE=1.
- Write mcycle←32'hFFFF_FFFF, mcycleh←0 → two cycles later mcycleh=1; minstret holds without `retire`.
- Trap and CSRRW mscratch same cycle → mscratch unchanged; assert `rst_n` low mid-sequence → all state at reset values immediately.

Source files
------------

// File: rtl/csr_pkg.sv
// Purpose: shared constants for the machine-mode CSR file (addresses, mstatus bits, misa, exception codes, CSR ops).
// Latency: n/a (constants and a pure read-modify-write helper).
// Backpressure: n/a.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mstatus fields
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // RV32I, machine mode only
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  // Synchronous exception codes (interrupt bit always 0)
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT      = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  // funct3[1:0] encodings
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] src);
    case (op)
      CSR_OP_RW: csr_apply = src;
      CSR_OP_RS: csr_apply = old | src;
      CSR_OP_RC: csr_apply = old & ~src;
      default:   csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Purpose: 64-bit free-running counter with increment enable and independent 32-bit lo/hi write ports.
// Latency: writes and increments visible one clk after the request.
// Backpressure: none; a half write takes priority over that cycle's increment and the other half holds.
// Ports: clk, rst_n (async active-low), inc, wr_lo, wr_hi, wr_data[31:0], cnt[63:0].
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[31:0]  <= wr_data;
      if (wr_hi) cnt[63:32] <= wr_data;
    end else if (inc) begin
      cnt <= cnt + 64'd1;  // wraps naturally at 2^64-1
    end
  end

endmodule

// File: rtl/csr_file.sv
// Purpose: machine-mode CSR file and trap unit; executes CSRRW/S/C(I), owns trap state and counters.
// Latency: rd_data/illegal/redirect/redirect_pc combinational; state updates visible next clk.
// Backpressure: none; trap beats mret beats CSR write in the same cycle.
// Ports: clk, rst_n, csr_w, csr_inm, f3, csr_addr, rs1_data, zimm, retire, trap, trap_cause,
//        trap_pc, trap_val, mret -> rd_data, illegal, redirect, redirect_pc.
// Build option: CSR_COUNTERS_EN enables mcycle/minstret and their user read-only aliases.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_w,
  input  logic        csr_inm,
  input  logic [2:0]  f3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        retire,
  input  logic        trap,
  input  logic [3:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic        mie, mpie;
  logic [29:0] mtvec_q;   // low two bits are hardwired 0
  logic [29:0] mepc_q;
  logic [31:0] mscratch_q, mcause_q, mtval_q;
  logic [31:0] mstatus_rd;

  logic [31:0] src, new_val, old_val;
  logic        impl, wr_eff, do_write;
  logic        f3_unused;
  csr_op_e     op;

  assign f3_unused = f3[2];  // immediate form is signalled by csr_inm instead
  assign op  = csr_op_e'(f3[1:0]);
  assign src = csr_inm ? {27'b0, zimm} : rs1_data;

  // RS/RC with a zero source are pure reads and must not fault on read-only CSRs
  assign wr_eff   = (op == CSR_OP_RW) || (src != 32'd0);
  assign illegal  = csr_w && (!impl || (op == CSR_OP_NONE) ||
                              ((csr_addr[11:10] == 2'b11) && wr_eff));
  assign do_write = csr_w && !illegal && wr_eff && !trap && !mret;
  assign new_val  = csr_apply(op, old_val, src);
  assign rd_data  = old_val;

  assign redirect    = trap | mret;
  assign redirect_pc = trap ? {mtvec_q, 2'b00} : {mepc_q, 2'b00};

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mpie;
    mstatus_rd[MSTATUS_MIE]  = mie;
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .wr_lo   (do_write && (csr_addr == CSR_MCYCLE)),
    .wr_hi   (do_write && (csr_addr == CSR_MCYCLEH)),
    .wr_data (new_val),
    .cnt     (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (retire),
    .wr_lo   (do_write && (csr_addr == CSR_MINSTRET)),
    .wr_hi   (do_write && (csr_addr == CSR_MINSTRETH)),
    .wr_data (new_val),
    .cnt     (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  always_comb begin
    impl    = 1'b1;
    old_val = '0;
    case (csr_addr)
      CSR_MSTATUS:  old_val = mstatus_rd;
      CSR_MISA:     old_val = MISA_VAL;
      CSR_MTVEC:    old_val = {mtvec_q, 2'b00};
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = {mepc_q, 2'b00};
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_MHARTID:  old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
`else
      // Counters absent: addresses decode as implemented, read 0, writes dropped
      CSR_MCYCLE, CSR_CYCLE, CSR_MCYCLEH, CSR_CYCLEH,
      CSR_MINSTRET, CSR_INSTRET, CSR_MINSTRETH, CSR_INSTRETH: old_val = '0;
`endif
      default:      impl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie        <= 1'b0;
      mpie       <= 1'b0;
      mtvec_q    <= RESET_MTVEC[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap) begin
      mepc_q   <= trap_pc[31:2];
      mcause_q <= {28'b0, trap_cause};
      mtval_q  <= trap_val;
      mpie     <= mie;
      mie      <= 1'b0;
    end else if (mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= new_val[MSTATUS_MIE];
          mpie <= new_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_q    <= new_val[31:2];
        CSR_MSCRATCH: mscratch_q <= new_val;
        CSR_MEPC:     mepc_q     <= new_val[31:2];
        CSR_MCAUSE:   mcause_q   <= new_val;
        CSR_MTVAL:    mtval_q    <= new_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Purpose: directed self-checking bench for csr_file (CSR ops, illegal decode, trap/mret, counters, reset).
// Latency: inputs driven on negedge, outputs sampled 1 time unit later, state committed on posedge.
// Backpressure: n/a.
module tb_csr_file;

  localparam logic [31:0] P_MTVEC = 32'h0000_2003;
  localparam logic [31:0] P_HART  = 32'd5;
  localparam logic [31:0] EXP_MTVEC = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_w, csr_inm, retire, trap, mret;
  logic [2:0]  f3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, trap_pc, trap_val;
  logic [4:0]  zimm;
  logic [3:0]  trap_cause;
  logic [31:0] rd_data, redirect_pc;
  logic        illegal, redirect;

  int tests = 0;
  int fails = 0;

  csr_file #(.RESET_MTVEC(P_MTVEC), .HART_ID(P_HART)) dut (
    .clk(clk), .rst_n(rst_n), .csr_w(csr_w), .csr_inm(csr_inm), .f3(f3),
    .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm), .retire(retire),
    .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .mret(mret), .rd_data(rd_data), .illegal(illegal), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    csr_w = 0; csr_inm = 0; f3 = 0; csr_addr = 0; rs1_data = 0; zimm = 0;
    retire = 0; trap = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret = 0;
  endtask

  // One CSR instruction occupying exactly one clock period
  task automatic do_csr(input logic [2:0] f, input logic [11:0] a, input logic [31:0] rs,
                        input logic inm, input logic [4:0] z,
                        output logic [31:0] rd, output logic ill);
    @(negedge clk);
    csr_w = 1; f3 = f; csr_addr = a; rs1_data = rs; csr_inm = inm; zimm = z;
    #1;
    rd = rd_data; ill = illegal;
    @(posedge clk); #1;
    clear_in();
  endtask

  // CSRRSI with zimm=0: pure read
  task automatic rd_csr(input logic [11:0] a, output logic [31:0] v);
    logic ill;
    do_csr(3'b110, a, 32'd0, 1'b1, 5'd0, v, ill);
  endtask

  logic [31:0] v, v2;
  logic        ill;

  initial begin
    clear_in();
    rst_n = 0;
    #1;
    check("reset_redirect", {31'b0, redirect}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;

    rd_csr(12'h300, v); check("reset_mstatus", v, 32'h0000_1800);
    rd_csr(12'h305, v); check("reset_mtvec", v, EXP_MTVEC);
    rd_csr(12'hF14, v); check("mhartid", v, P_HART);
    rd_csr(12'h301, v); check("misa", v, 32'h4000_0100);
    rd_csr(12'h341, v); check("reset_mepc", v, 32'd0);
`ifdef CSR_COUNTERS_EN
    rd_csr(12'hB00, v); check("reset_mcycle_small", {31'b0, (v != 0) && (v < 32'd20)}, 32'd1);
    rd_csr(12'hB80, v); check("reset_mcycleh", v, 32'd0);
`else
    rd_csr(12'hB00, v); check("nocnt_mcycle", v, 32'd0);
`endif

    // mscratch read-modify-write
    do_csr(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, 5'd0, v, ill);
    check("rw_mscratch_old", v, 32'd0);
    check("rw_mscratch_ill", {31'b0, ill}, 32'd0);
    do_csr(3'b010, 12'h340, 32'd0, 1'b0, 5'd0, v, ill);
    check("rs0_mscratch", v, 32'hDEAD_BEEF);
    rd_csr(12'h340, v); check("rs0_nowrite", v, 32'hDEAD_BEEF);
    do_csr(3'b111, 12'h340, 32'd0, 1'b1, 5'h0F, v, ill);
    check("rci_old", v, 32'hDEAD_BEEF);
    rd_csr(12'h340, v); check("rci_new", v, 32'hDEAD_BEE0);
    do_csr(3'b110, 12'h340, 32'd0, 1'b1, 5'h01, v, ill);
    rd_csr(12'h340, v); check("rsi_new", v, 32'hDEAD_BEE1);

    // illegal decode
`ifdef CSR_COUNTERS_EN
    rd_csr(12'hC00, v2);
`endif
    do_csr(3'b001, 12'hC00, 32'd5, 1'b0, 5'd0, v, ill);
    check("rw_ro_illegal", {31'b0, ill}, 32'd1);
    rd_csr(12'hC00, v);
`ifdef CSR_COUNTERS_EN
    check("cycle_unchanged", v, v2 + 32'd2);
`else
    check("cycle_unchanged", v, 32'd0);
`endif
    do_csr(3'b010, 12'hC00, 32'd0, 1'b0, 5'd0, v, ill);
    check("rs0_ro_legal", {31'b0, ill}, 32'd0);
    do_csr(3'b010, 12'h7C0, 32'd0, 1'b0, 5'd0, v, ill);
    check("unimpl_illegal", {31'b0, ill}, 32'd1);
    do_csr(3'b000, 12'h340, 32'd0, 1'b0, 5'd0, v, ill);
    check("f3_zero_illegal", {31'b0, ill}, 32'd1);
    do_csr(3'b001, 12'hF14, 32'd0, 1'b0, 5'd0, v, ill);
    check("rw_mhartid_illegal", {31'b0, ill}, 32'd1);

    // trap entry and mret
    do_csr(3'b110, 12'h300, 32'd0, 1'b1, 5'h08, v, ill);
    rd_csr(12'h300, v); check("mie_set", v, 32'h0000_1808);
    @(negedge clk);
    trap = 1; trap_cause = 4'd2; trap_pc = 32'h0000_0102; trap_val = 32'h0000_0055;
    #1;
    check("trap_redirect", {31'b0, redirect}, 32'd1);
    check("trap_redirect_pc", redirect_pc, EXP_MTVEC);
    @(posedge clk); #1; clear_in();
    rd_csr(12'h341, v); check("trap_mepc", v, 32'h0000_0100);
    rd_csr(12'h342, v); check("trap_mcause", v, 32'd2);
    rd_csr(12'h343, v); check("trap_mtval", v, 32'h0000_0055);
    rd_csr(12'h300, v); check("trap_mstatus", v, 32'h0000_1880);
    @(negedge clk);
    mret = 1;
    #1;
    check("mret_redirect", {31'b0, redirect}, 32'd1);
    check("mret_redirect_pc", redirect_pc, 32'h0000_0100);
    @(posedge clk); #1; clear_in();
    rd_csr(12'h300, v); check("mret_mstatus", v, 32'h0000_1888);

    // counters
`ifdef CSR_COUNTERS_EN
    do_csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 5'd0, v, ill);
    do_csr(3'b001, 12'hB80, 32'd0, 1'b0, 5'd0, v, ill);
    rd_csr(12'hB00, v); check("mcycle_lo_held", v, 32'hFFFF_FFFF);
    rd_csr(12'hB80, v); check("mcycleh_carry", v, 32'd1);
    rd_csr(12'hB02, v); check("minstret_idle", v, 32'd0);
    rd_csr(12'hB02, v); check("minstret_hold", v, 32'd0);
    @(negedge clk) retire = 1;
    @(posedge clk); #1; retire = 0;
    rd_csr(12'hB02, v); check("minstret_retire", v, 32'd1);
    rd_csr(12'hC02, v); check("instret_alias", v, 32'd1);
`else
    do_csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 5'd0, v, ill);
    check("nocnt_wr_legal", {31'b0, ill}, 32'd0);
    rd_csr(12'hB00, v); check("nocnt_wr_dropped", v, 32'd0);
`endif

    // trap with CSR write in the same cycle: write suppressed, rd_data still driven
    @(negedge clk);
    trap = 1; trap_cause = 4'd11; trap_pc = 32'h0000_0200; trap_val = 32'd0;
    csr_w = 1; f3 = 3'b001; csr_addr = 12'h340; rs1_data = 32'h1234_5678;
    #1;
    check("trapw_rd_data", rd_data, 32'hDEAD_BEE1);
    @(posedge clk); #1; clear_in();
    rd_csr(12'h340, v); check("trapw_mscratch", v, 32'hDEAD_BEE1);
    rd_csr(12'h341, v); check("trapw_mepc", v, 32'h0000_0200);

    // async reset mid-trap
    @(negedge clk);
    trap = 1; trap_pc = 32'h0000_0300;
    csr_w = 1; f3 = 3'b010; csr_addr = 12'h341;
    rst_n = 0;
    #1;
    check("rst_mepc_immediate", rd_data, 32'd0);
    trap = 0;
    #1;
    check("rst_redirect_low", {31'b0, redirect}, 32'd0);
    @(posedge clk); #1; clear_in();
    rd_csr(12'h340, v); check("rst_mscratch", v, 32'd0);
    rd_csr(12'h300, v); check("rst_mstatus", v, 32'h0000_1800);
    rd_csr(12'h305, v); check("rst_mtvec", v, EXP_MTVEC);
    rd_csr(12'h342, v); check("rst_mcause", v, 32'd0);
`ifdef CSR_COUNTERS_EN
    rd_csr(12'hB80, v); check("rst_mcycleh", v, 32'd0);
`endif
    @(negedge clk) rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
